// File: rtl/data_cache_pkg.sv
// Shared constants, address helpers and FSM encoding for the direct-mapped
// write-through data cache.
package data_cache_pkg;

   localparam logic [31:0] DATA_BASE = 32'd1024;
   localparam int          INDEX_W   = 6;
   localparam int          TAG_W     = 11;
   localparam int          LINES     = 1 << INDEX_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR      = 2'd2
   } state_t;

   // Byte offset bits [1:0] are dropped: accesses are word-aligned only.
   function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - DATA_BASE;
      return off[INDEX_W+1:2];
   endfunction

   function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - DATA_BASE;
      return off[INDEX_W+TAG_W+1:INDEX_W+2];
   endfunction

endpackage

// File: rtl/data_cache_if.sv
// Bus bundle between the MEM stage, the data cache and the backing data memory.
interface data_cache_if;
   // Pipeline side: a request (MEM_R_EN/MEM_W_EN) is held until ready=1 in the
   // same cycle; that cycle completes it. Backend side: mem_r_en/mem_w_en stay
   // high with stable mem_addr/mem_wdata until the cycle mem_ready=1.
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] ALU_Res;
   logic [31:0] Val_Rm;
   logic [31:0] out;
   logic        ready;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport slave (
      input  MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, mem_rdata, mem_ready,
      output out, ready, mem_r_en, mem_w_en, mem_addr, mem_wdata
   );

   modport master (
      output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, mem_rdata, mem_ready,
      input  out, ready, mem_r_en, mem_w_en, mem_addr, mem_wdata
   );
endinterface

// File: rtl/data_cache_array.sv
// Valid/tag/data storage for the data cache: combinational lookup plus one
// synchronous fill/update port. Only the valid bits are cleared by reset.
module data_cache_array
   import data_cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] lk_index,
   input  logic [TAG_W-1:0]   lk_tag,
   output logic               lk_hit,
   output logic [31:0]        lk_data,
   input  logic               wr_en,
   input  logic               wr_fill,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [31:0]        wr_data
);

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];
   logic [31:0]      data [LINES];

   assign lk_hit  = valid[lk_index] && (tags[lk_index] == lk_tag);
   assign lk_data = data[lk_index];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (wr_en && wr_fill) begin
         valid[wr_index] <= 1'b1;
      end
   end

   // An update (wr_fill=0) rewrites data of an already-matching line only.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data[wr_index] <= wr_data;
         if (wr_fill) begin
            tags[wr_index] <= wr_tag;
         end
      end
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate MEM-stage data cache.
// Optional hit/miss counters are built when DATA_CACHE_STATS_EN is defined.
module data_cache
   import data_cache_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   data_cache_if.slave  bus,
   output state_t       dbg_state
`ifdef DATA_CACHE_STATS_EN
   ,
   output logic [15:0]  hit_cnt,
   output logic [15:0]  miss_cnt
`endif
);

   state_t      state;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        mem_r_en_q;
   logic        mem_w_en_q;

   logic [31:0] lk_addr;
   logic        lk_hit;
   logic [31:0] lk_data;
   logic        ready_c;
   logic [31:0] out_c;
   logic        arr_we;
   logic        arr_fill;
   logic        rd_hit;
   logic        rd_done;

   // Once a transaction is in flight only the latched address is looked up.
   assign lk_addr = (state == IDLE) ? bus.ALU_Res : lat_addr;

   data_cache_array u_array (
      .clk      (clk),
      .rst      (rst),
      .lk_index (addr_index(lk_addr)),
      .lk_tag   (addr_tag(lk_addr)),
      .lk_hit   (lk_hit),
      .lk_data  (lk_data),
      .wr_en    (arr_we),
      .wr_fill  (arr_fill),
      .wr_index (addr_index(lat_addr)),
      .wr_tag   (addr_tag(lat_addr)),
      .wr_data  ((state == WR) ? lat_wdata : bus.mem_rdata)
   );

   always_comb begin
      ready_c  = 1'b1;
      out_c    = '0;
      arr_we   = 1'b0;
      arr_fill = 1'b0;
      rd_hit   = 1'b0;
      rd_done  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.MEM_W_EN) begin
               ready_c = 1'b0;
            end else if (bus.MEM_R_EN) begin
               if (lk_hit) begin
                  out_c  = lk_data;
                  rd_hit = 1'b1;
               end else begin
                  ready_c = 1'b0;
               end
            end
         end
         RD_MISS: begin
            ready_c = bus.mem_ready;
            if (bus.mem_ready) begin
               out_c    = bus.mem_rdata;
               arr_we   = !rst;
               arr_fill = 1'b1;
               rd_done  = 1'b1;
            end
         end
         WR: begin
            ready_c = bus.mem_ready;
            arr_we  = bus.mem_ready && lk_hit && !rst;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         mem_r_en_q <= 1'b0;
         mem_w_en_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.MEM_W_EN) begin
                  lat_addr   <= bus.ALU_Res;
                  lat_wdata  <= bus.Val_Rm;
                  mem_w_en_q <= 1'b1;
                  state      <= WR;
               end else if (bus.MEM_R_EN && !lk_hit) begin
                  lat_addr   <= bus.ALU_Res;
                  mem_r_en_q <= 1'b1;
                  state      <= RD_MISS;
               end
            end
            RD_MISS: begin
               if (bus.mem_ready) begin
                  mem_r_en_q <= 1'b0;
                  state      <= IDLE;
               end
            end
            WR: begin
               if (bus.mem_ready) begin
                  mem_w_en_q <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ready     = ready_c;
   assign bus.out       = out_c;
   assign bus.mem_r_en  = mem_r_en_q;
   assign bus.mem_w_en  = mem_w_en_q;
   assign bus.mem_addr  = lat_addr;
   assign bus.mem_wdata = lat_wdata;
   assign dbg_state     = state;

`ifdef DATA_CACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (rd_hit && hit_cnt != 16'hFFFF) begin
            hit_cnt <= hit_cnt + 16'd1;
         end
         if (rd_done && miss_cnt != 16'hFFFF) begin
            miss_cnt <= miss_cnt + 16'd1;
         end
      end
   end
`else
   logic unused_stats;
   assign unused_stats = rd_hit ^ rd_done;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed and random loads/stores against
// a small backing-memory and line-occupancy model with an expected-data queue.
module tb_data_cache;
   import data_cache_pkg::*;

   logic   clk = 1'b0;
   logic   rst;
   state_t dbg_state;
`ifdef DATA_CACHE_STATS_EN
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;
`endif

   always #5 clk = ~clk;

   data_cache_if bus ();

   data_cache dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
`ifdef DATA_CACHE_STATS_EN
      ,
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
`endif
   );

   int          checks   = 0;
   int          failures = 0;
   int          n_hit    = 0;
   int          n_miss   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mem_model [logic [31:0]];
   logic        m_valid [LINES];
   logic [TAG_W-1:0] m_tag [LINES];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic get_word(input logic [31:0] addr, output logic [31:0] w);
      if (!mem_model.exists(addr)) mem_model[addr] = $urandom;
      w = mem_model[addr];
   endtask

   task automatic idle_bus();
      bus.MEM_R_EN = 1'b0;
      bus.MEM_W_EN = 1'b0;
      bus.ALU_Res  = '0;
      bus.Val_Rm   = '0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      n_hit  = 0;
      n_miss = 0;
   endtask

   task automatic check_idle_outputs(input string pfx);
      check({pfx, "_ready"}, 32'(bus.ready), 32'd1);
      check({pfx, "_out"}, bus.out, 32'd0);
      check({pfx, "_r_en"}, 32'(bus.mem_r_en), 32'd0);
      check({pfx, "_w_en"}, 32'(bus.mem_w_en), 32'd0);
      check({pfx, "_state"}, 32'(dbg_state), 32'(IDLE));
   endtask

   // Called #1 after a rising edge; returns #1 after the completing edge.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat);
      logic [31:0]      exp;
      logic [INDEX_W-1:0] idx;
      logic [TAG_W-1:0] tg;
      logic             hit;
      idx = addr_index(addr);
      tg  = addr_tag(addr);
      hit = m_valid[idx] && (m_tag[idx] == tg);
      bus.MEM_R_EN = rd;
      bus.MEM_W_EN = wr;
      bus.ALU_Res  = addr;
      bus.Val_Rm   = wdata;
      if (rd && !wr) begin
         get_word(addr, exp);
         exp_q.push_back(exp);
      end
      #1;
      if (rd && !wr && hit) begin
         check("hit_ready", 32'(bus.ready), 32'd1);
         check("hit_r_en", 32'(bus.mem_r_en), 32'd0);
         exp = exp_q.pop_front();
         check("hit_data", bus.out, exp);
         n_hit++;
         @(posedge clk); #1;
         idle_bus();
         return;
      end
      check("req_ready", 32'(bus.ready), 32'd0);
      check("req_out", bus.out, 32'd0);
      @(posedge clk); #1;
      // Wiggle the request side; the in-flight transaction must ignore it.
      bus.MEM_R_EN = 1'b0;
      bus.MEM_W_EN = 1'b0;
      bus.ALU_Res  = 32'hDEAD_BEEC;
      bus.Val_Rm   = ~wdata;
      for (int i = 0; i <= lat; i++) begin
         if (i == lat) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = wr ? $urandom : mem_model[addr];
         end
         #1;
         check("be_w_en", 32'(bus.mem_w_en), 32'(wr));
         check("be_r_en", 32'(bus.mem_r_en), 32'(!wr));
         check("be_addr", bus.mem_addr, addr);
         if (wr) check("be_wdata", bus.mem_wdata, wdata);
         check("be_ready", 32'(bus.ready), 32'(i == lat));
         if (i == lat && !wr) begin
            exp = exp_q.pop_front();
            check("miss_data", bus.out, exp);
         end else begin
            check("be_out", bus.out, 32'd0);
         end
         @(posedge clk); #1;
      end
      bus.mem_ready = 1'b0;
      if (wr) begin
         mem_model[addr] = wdata;
      end else begin
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
         n_miss++;
      end
      check("done_r_en", 32'(bus.mem_r_en), 32'd0);
      check("done_w_en", 32'(bus.mem_w_en), 32'd0);
      check("done_state", 32'(dbg_state), 32'(IDLE));
      idle_bus();
   endtask

   initial begin
      logic [31:0] a;
      rst           = 1'b1;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      idle_bus();
      clear_model();
      mem_model[32'd1024] = 32'hCAFE_0001;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle_outputs("rst");
      check("rst_addr", bus.mem_addr, 32'd0);
      check("rst_wdata", bus.mem_wdata, 32'd0);

      access(1'b1, 1'b0, 32'd1024, 32'd0, 0);              // cold miss
      access(1'b1, 1'b0, 32'd1024, 32'd0, 0);              // hit
      access(1'b0, 1'b1, 32'd1024, 32'h1234_5678, 0);      // write hit
      access(1'b1, 1'b0, 32'd1024, 32'd0, 0);              // hit, new data
      access(1'b0, 1'b1, 32'd1028, 32'hA5A5_0028, 1);      // write miss
      access(1'b1, 1'b0, 32'd1028, 32'd0, 2);              // no allocate: miss
      access(1'b1, 1'b0, 32'd1280, 32'd0, 1);              // conflict, tag 1
      access(1'b1, 1'b0, 32'd1024, 32'd0, 0);              // evicted: miss
      access(1'b1, 1'b1, 32'd1040, 32'h0BAD_1040, 1);      // write wins

      for (int n = 0; n < 24; n++) begin
         a = DATA_BASE + 32'(4 * $urandom_range(0, 3)) + 32'(256 * $urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0)
            access(1'b0, 1'b1, a, $urandom, $urandom_range(0, 2));
         else
            access(1'b1, 1'b0, a, 32'd0, $urandom_range(0, 2));
      end

`ifdef DATA_CACHE_STATS_EN
      check("hit_cnt", 32'(hit_cnt), 32'(n_hit));
      check("miss_cnt", 32'(miss_cnt), 32'(n_miss));
`endif

      // Reset while a read miss is outstanding, with mem_ready already high.
      mem_model[32'd1184] = 32'h0BAD_F00D;
      bus.MEM_R_EN = 1'b1;
      bus.ALU_Res  = 32'd1184;
      #1;
      check("abort_req_ready", 32'(bus.ready), 32'd0);
      @(posedge clk); #1;
      idle_bus();
      check("abort_r_en_before", 32'(bus.mem_r_en), 32'd1);
      rst           = 1'b1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h0000_0055;
      @(posedge clk); #1;
      rst           = 1'b0;
      bus.mem_ready = 1'b0;
      clear_model();
      check_idle_outputs("abort");
      check("abort_addr", bus.mem_addr, 32'd0);
      access(1'b1, 1'b0, 32'd1184, 32'd0, 1);               // not filled: miss
      access(1'b1, 1'b0, 32'd1184, 32'd0, 0);               // now a hit

`ifdef DATA_CACHE_STATS_EN
      check("hit_cnt_after_rst", 32'(hit_cnt), 32'(n_hit));
      check("miss_cnt_after_rst", 32'(miss_cnt), 32'(n_miss));
`endif
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
